// File: rtl/exc_unit_if.sv
// exc_unit_if: controller <-> exception unit handshake and register bus.
// master = controller side, slave = exception unit side.
interface exc_unit_if #(
   parameter int unsigned DW = 64
);
   logic          Exc;
   logic [3:0]    EStatus;
   logic          ERet;
   logic          ExtIAck;
   logic [DW-1:0] pc;
   logic          ExtIRQ;
   logic          ExcAck;
   logic [1:0]    pc_sel;
   logic [DW-1:0] vec_addr;
   logic [DW-1:0] elr;
   logic [3:0]    esr;
   logic          in_handler;
   logic          halt;

   modport master (
      output Exc, EStatus, ERet, ExtIAck, pc,
      input  ExtIRQ, ExcAck, pc_sel, vec_addr, elr, esr, in_handler, halt
   );

   modport slave (
      input  Exc, EStatus, ERet, ExtIAck, pc,
      output ExtIRQ, ExcAck, pc_sel, vec_addr, elr, esr, in_handler, halt
   );
endinterface

// File: rtl/exc_unit.sv
// exc_unit: exception/interrupt unit for the single-cycle core.
// Synchronises and latches the external IRQ, accepts exceptions, saves
// ELR/ESR, selects the next PC and halts the core on a double fault.
// Optional macro EXC_COUNT_EN adds a saturating accepted-exception counter.
module exc_unit #(
   parameter int unsigned       DW          = 64,
   parameter logic [DW-1:0]     EXC_VECTOR  = DW'(64'h0000_0000_0000_00D8),
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             irq_in,
   exc_unit_if.slave        bus
`ifdef EXC_COUNT_EN
   ,
   output logic [15:0]      exc_count
`endif
);

   localparam int unsigned ESR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALT    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                r_sync_prev;
   logic                r_pending;
   logic [DW-1:0]       r_elr;
   logic [ESR_W-1:0]    r_esr;
   logic                w_irq_rise;
   logic                w_exc_ack;
   logic [1:0]          w_pc_sel;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; Exc beats ERet in HANDLER, HALT only leaves on reset
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (bus.Exc) w_state_nxt = ST_HANDLER;
         ST_HANDLER: begin
            if (bus.Exc)       w_state_nxt = ST_HALT;
            else if (bus.ERet) w_state_nxt = ST_IDLE;
         end
         ST_HALT:    w_state_nxt = ST_HALT;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Same-cycle acknowledge and next-PC select
   always_comb begin
      w_exc_ack = 1'b0;
      w_pc_sel  = 2'b00;
      if (!reset) begin
         case (r_state)
            ST_IDLE: if (bus.Exc) begin
               w_exc_ack = 1'b1;
               w_pc_sel  = 2'b01;
            end
            ST_HANDLER: if (!bus.Exc && bus.ERet) w_pc_sel = 2'b10;
            default: ;
         endcase
      end
   end

   // IRQ synchroniser chain and edge-detect history
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync      <= '0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], irq_in};
         r_sync_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_irq_rise = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

   // Pending latch: a new edge wins over a simultaneous acknowledge
   always_ff @(posedge clk) begin
      if (reset)           r_pending <= 1'b0;
      else if (w_irq_rise) r_pending <= 1'b1;
      else if (bus.ExtIAck) r_pending <= 1'b0;
   end

   // Link and syndrome registers; a double fault marks bit 3 and keeps ELR
   always_ff @(posedge clk) begin
      if (reset) begin
         r_elr <= '0;
         r_esr <= '0;
      end else if (r_state == ST_IDLE && bus.Exc) begin
         r_elr <= bus.pc;
         r_esr <= bus.EStatus;
      end else if (r_state == ST_HANDLER && bus.Exc) begin
         r_esr <= bus.EStatus | 4'b1000;
      end
   end

`ifdef EXC_COUNT_EN
   logic [15:0] r_exc_count;

   // Saturating count of accepted exceptions
   always_ff @(posedge clk) begin
      if (reset)
         r_exc_count <= '0;
      else if (w_exc_ack && r_exc_count != 16'hFFFF)
         r_exc_count <= r_exc_count + 16'd1;
   end

   assign exc_count = r_exc_count;
`endif

   assign bus.ExtIRQ     = r_pending & (r_state == ST_IDLE) & ~reset;
   assign bus.ExcAck     = w_exc_ack;
   assign bus.pc_sel     = w_pc_sel;
   assign bus.vec_addr   = EXC_VECTOR;
   assign bus.elr        = r_elr;
   assign bus.esr        = r_esr;
   assign bus.in_handler = (r_state == ST_HANDLER);
   assign bus.halt       = (r_state == ST_HALT);

endmodule

// File: doc/exc_unit.md
Name: exc_unit

Overview:
- Sequential exception/interrupt unit paired with the single-cycle controller.
- Upstream role: synchronises the raw external interrupt, latches it as pending, and presents a masked ExtIRQ to the controller.
- Downstream role: consumes the controller's Exc/EStatus/ERet, generates ExcAck, and saves ELR/ESR.
- Drives the next-PC select (normal / exception vector / return to ELR) and halts the core on a double fault.

Parameters:
DW, 64, datapath / PC width
EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address driven on vec_addr
SYNC_STAGES, 2, flip-flop stages on irq_in (legal range 2..4)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
irq_in  input  1  raw asynchronous external interrupt request (level)
Exc  input  1  exception request from controller (combinational, same cycle)
EStatus  input  4  cause code from controller: 0001 external IRQ, 0010 not-an-instruction
ERet  input  1  exception-return instruction decoded this cycle
ExtIAck  input  1  IRQ acknowledge from controller (ExcAck & ExtIRQ)
pc  input  DW  address of the instruction currently executing
ExtIRQ  output  1  masked pending interrupt, to controller
ExcAck  output  1  exception accepted this cycle (combinational)
pc_sel  output  2  next-PC select: 00 PC+4/branch, 01 vec_addr, 10 elr
vec_addr  output  DW  constant EXC_VECTOR
elr  output  DW  exception link register
esr  output  4  exception syndrome register
in_handler  output  1  high while state==HANDLER
halt  output  1  double fault; core must stop fetching

Behaviour:
- Reset (synchronous): state=IDLE; elr=0; esr=0; pending=0; sync chain=0; halt=0. Combinational outputs resolve to ExtIRQ=0, ExcAck=0, pc_sel=00. Reset overrides every other input in every state, including mid-handler and HALT.
- IRQ path:
  - irq_in passes through SYNC_STAGES flops.
  - A rising edge of the synchronised signal (registered previous value 0, current 1) sets pending.
  - ExtIAck clears pending at the edge. If a set and a clear land on the same edge, set wins.
  - Latency: irq_in rising before edge N gives pending=1 after edge N+SYNC_STAGES.
- ExtIRQ = pending & (state==IDLE). The interrupt is masked in HANDLER and HALT.
- FSM states: IDLE, HANDLER, HALT.
  - IDLE, Exc=1:
    - ExcAck=1 and pc_sel=01 in the same cycle.
    - At the edge: elr<=pc, esr<=EStatus, state<=HANDLER.
    - elr holds the address of the instruction that was not retired; ERet re-executes it.
  - IDLE, ERet=1 with Exc=0: ignored. pc_sel=00, no state change.
  - HANDLER, ERet=1 with Exc=0: pc_sel=10, state<=IDLE at the edge. elr/esr are retained.
  - HANDLER, Exc=1 (only NotAnInstr is possible, since IRQ is masked):
    - Double fault: ExcAck=0, pc_sel=00.
    - At the edge: esr<=EStatus|4'b1000, state<=HALT. elr is unchanged.
    - Exc takes priority over a simultaneous ERet.
  - HALT: halt=1; ExcAck=0; pc_sel=00. All inputs are ignored; only reset exits.
- An IRQ arriving while in HANDLER stays pending. ExtIRQ rises in the first cycle after the ERet edge.
- ExcAck and pc_sel are purely combinational from state plus Exc/ERet. All other outputs are registered.

Optional Feature:
- Macro: EXC_COUNT_EN.
- Defined:
  - Adds output exc_count[15:0], a saturating count of accepted exceptions.
  - Increments on each edge where ExcAck=1; holds at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- Reset: hold reset 2 cycles with irq_in=1 and Exc=1 → ExtIRQ=0, ExcAck=0, pc_sel=00, elr=0, esr=0, halt=0; release → pending=1 exactly SYNC_STAGES+1 edges later.
- IRQ entry: pending=1, IDLE, controller drives Exc=1, EStatus=0001, pc=0x40, ExtIAck=1 → same cycle ExcAck=1, pc_sel=01, vec_addr=0xD8; next cycle elr=0x40, esr=0001, in_handler=1, ExtIRQ=0, pending=0.
- Bad opcode: IDLE, Exc=1, EStatus=0010, pc=0x100 → elr=0x100, esr=0010; then ERet=1 → pc_sel=10, elr=0x100, next state IDLE.
- Masked IRQ: in HANDLER, pulse irq_in for 1 cycle → ExtIRQ stays 0 until ERet; ExtIRQ=1 in the cycle after the ERet edge.
- Double fault: in HANDLER, Exc=1, EStatus=0010, ERet=1 same cycle → ExcAck=0, pc_sel=00; next cycle halt=1, esr=1010; later ERet/Exc have no effect; reset returns to IDLE with halt=0.
- Set/clear race: synchronised rising edge coincides with ExtIAck=1 → pending remains 1. With EXC_COUNT_EN: 3 accepted exceptions → exc_count=3; a forced preload of 0xFFFF plus one more exception stays 0xFFFF.
